// File: rtl/matrix_deskew.sv
// matrix_deskew: removes the per-lane time skew of the systolic array's
// south-edge outputs, rebuilds whole result rows, queues them in a small
// FIFO and hands them to the result writer over valid/ready.

// One lane's fixed delay line. Data and valid travel together so a lane's
// element and its qualifier always line up at the output.
module matrix_deskew_lane #(
  parameter int STAGES = 0,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  if (STAGES == 0) begin : g_thru
    // The last lane is already the latest to arrive: no delay needed.
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_dly
    logic [STAGES:1]            vld_pipe;
    logic [STAGES:1][WIDTH-1:0] dat_pipe;

    // Free-running shift: the array never stalls, so neither does this.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[1] <= in_valid;
        dat_pipe[1] <= in_data;
        for (int s = 2; s <= STAGES; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          dat_pipe[s] <= dat_pipe[s-1];
        end
      end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = dat_pipe[STAGES];
  end
endmodule

module matrix_deskew #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic                     clr_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [15:0]              out_row,
  output logic                     misalign,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = LANES * WIDTH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [15:0]   row;
  } entry_t;

  logic [LANES-1:0]            al_vld;
  logic [LANES-1:0][WIDTH-1:0] al_dat;

  // Lane i is early by LANES-1-i cycles relative to the last lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    matrix_deskew_lane #(
      .STAGES (LANES - 1 - gi),
      .WIDTH  (WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[gi]),
      .in_data   (in_data[gi*WIDTH +: WIDTH]),
      .out_valid (al_vld[gi]),
      .out_data  (al_dat[gi])
    );
  end

  logic complete, partial, pop, push, drop, full;

  // Classify the aligned row and decide FIFO actions. A full FIFO still
  // accepts a row when the head leaves in the same cycle.
  always_comb begin
    complete = &al_vld;
    partial  = (|al_vld) && !complete;
    full     = (level == LW'(DEPTH));
    pop      = out_valid && out_ready;
    push     = complete && (!full || pop);
    drop     = complete && full && !pop;
  end

  entry_t [DEPTH-1:0] mem;
  logic   [AW-1:0]    wr_ptr, rd_ptr;
  logic   [15:0]      row_cnt;

  // Row FIFO; each entry carries its row index, taken from a counter that
  // only advances on accepted rows so drops and misaligned rows skip no index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      row_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: al_dat, row: row_cnt};
        wr_ptr      <= wr_ptr + 1'b1;
        row_cnt     <= row_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr].data;
  assign out_row   = mem[rd_ptr].row;

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (clr_err) begin
        misalign <= 1'b0;
        overflow <= 1'b0;
      end
      if (partial) misalign <= 1'b1;
      if (drop)    overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_matrix_deskew.sv
// tb_matrix_deskew: directed + randomized stimulus for matrix_deskew,
// checked against a row-level reference model (input history lookup plus
// a queue of expected rows).
module tb_matrix_deskew;
  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = LANES * WIDTH;
  localparam int NCYC  = 2048;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [LANES-1:0]       in_valid;
  logic [DW-1:0]          in_data;
  logic                   clr_err;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW-1:0]          out_data;
  logic [15:0]            out_row;
  logic                   misalign;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;

  matrix_deskew #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .misalign  (misalign),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [15:0]   r;
  } row_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_cyc = 0;

  logic [LANES-1:0] future_v [NCYC];
  logic [DW-1:0]    future_d [NCYC];
  logic [LANES-1:0] hv [NCYC];
  logic [DW-1:0]    hd [NCYC];

  row_t        q[$];
  logic [15:0] m_cnt;
  logic        m_mis, m_ovf;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Array emits lane i of a row starting at t0 in cycle t0+i.
  task automatic sched_row(int t0, logic [DW-1:0] d, logic [LANES-1:0] mask);
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        future_v[t0+i][i] = 1'b1;
        future_d[t0+i][i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
      end
    end
  endtask

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = '0;
    m_mis = 1'b0;
    m_ovf = 1'b0;
    rst_cyc = cyc;
  endtask

  // One clock cycle: drive, check registered state at negedge, advance model.
  task automatic step();
    logic [LANES-1:0] av;
    logic [DW-1:0]    ad;
    logic             cmpl, part, pp, ps;
    row_t             nr;
    in_valid = future_v[cyc];
    in_data  = future_d[cyc];
    hv[cyc]  = in_valid;
    hd[cyc]  = in_data;
    @(negedge clk);
    chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
    chk("level", DW'(level), DW'(q.size()));
    chk("misalign", DW'(misalign), DW'(m_mis));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_row", DW'(out_row), DW'(q[0].r));
    end
    // Aligned row: lane i's element from LANES-1-i cycles ago.
    av = '0;
    ad = '0;
    for (int i = 0; i < LANES; i++) begin
      int idx;
      idx = cyc - (LANES - 1 - i);
      if (idx >= rst_cyc) begin
        av[i] = hv[idx][i];
        ad[i*WIDTH +: WIDTH] = hd[idx][i*WIDTH +: WIDTH];
      end
    end
    cmpl = (av == '1);
    part = (av != '0) && !cmpl;
    pp   = (q.size() != 0) && out_ready;
    ps   = cmpl && (q.size() < DEPTH || pp);
    if (pp) void'(q.pop_front());
    if (ps) begin
      nr.d = ad;
      nr.r = m_cnt;
      q.push_back(nr);
      m_cnt = m_cnt + 16'd1;
    end
    if (clr_err) begin
      m_mis = 1'b0;
      m_ovf = 1'b0;
    end
    if (part) m_mis = 1'b1;
    if (cmpl && !ps) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  initial begin
    logic [DW-1:0] d;
    int c0;
    for (int k = 0; k < NCYC; k++) begin
      future_v[k] = '0;
      future_d[k] = '0;
      hv[k] = '0;
      hd[k] = '0;
    end
    reset = 1'b0;
    in_valid = '0;
    in_data = '0;
    clr_err = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_level", DW'(level), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_row", DW'(out_row), '0);
    chk("rst_misalign", DW'(misalign), '0);
    chk("rst_overflow", DW'(overflow), '0);
    #19 reset = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    model_reset();

    // 1: single directed row, lane i = 0x10+i starting at cycle 2.
    for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = WIDTH'(16 + i);
    sched_row(2, d, '1);
    run(10);

    // 2: eight back-to-back rows, row r lane i = r*4+i.
    c0 = cyc;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = WIDTH'(r * 4 + i);
      sched_row(c0 + 1 + r, d, '1);
    end
    run(16);

    // 3: backpressure; fifth row overflows, then drain.
    out_ready = 1'b0;
    c0 = cyc;
    for (int r = 0; r < 5; r++) sched_row(c0 + 1 + r, rnd_row(), '1);
    run(12);
    out_ready = 1'b1;
    run(8);

    // 4: full FIFO with a pop in the cycle the fifth row completes.
    out_ready = 1'b0;
    c0 = cyc;
    for (int r = 0; r < 5; r++) sched_row(c0 + 1 + r, rnd_row(), '1);
    run(c0 + 5 + LANES - 1 - cyc);
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    run(2);
    out_ready = 1'b1;
    run(8);

    // 5: lane 2 withheld, then a good row; clear; then set-wins-over-clear.
    c0 = cyc;
    sched_row(c0 + 1, rnd_row(), 4'b1011);
    sched_row(c0 + 2, rnd_row(), '1);
    run(8);
    clr_err = 1'b1;
    run(1);
    clr_err = 1'b0;
    run(1);
    c0 = cyc;
    sched_row(c0 + 1, rnd_row(), 4'b0111);
    run(c0 + 1 + LANES - 1 - cyc);
    clr_err = 1'b1;
    run(1);
    clr_err = 1'b0;
    run(2);
    clr_err = 1'b1;
    run(1);
    clr_err = 1'b0;

    // 6: async reset with three rows buffered.
    out_ready = 1'b0;
    c0 = cyc;
    for (int r = 0; r < 3; r++) sched_row(c0 + 1 + r, rnd_row(), '1);
    run(8);
    in_valid = future_v[cyc];
    in_data = future_d[cyc];
    reset = 1'b0;
    #2;
    chk("arst_out_valid", DW'(out_valid), '0);
    chk("arst_level", DW'(level), '0);
    chk("arst_out_data", out_data, '0);
    chk("arst_misalign", DW'(misalign), '0);
    chk("arst_overflow", DW'(overflow), '0);
    model_reset();
    #2 reset = 1'b1;
    out_ready = 1'b1;
    sched_row(cyc + 1, rnd_row(), '1);
    run(8);

    // 7: random soak: random rows, masks, ready and clears.
    repeat (400) begin
      if ($urandom_range(1, 0) == 1) begin
        if ($urandom_range(7, 0) != 0) sched_row(cyc + 1, rnd_row(), '1);
        else sched_row(cyc + 1, rnd_row(), LANES'($urandom));
      end
      out_ready = ($urandom_range(3, 0) != 0);
      clr_err = ($urandom_range(15, 0) == 0);
      step();
    end
    clr_err = 1'b0;
    out_ready = 1'b1;
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_deskew.md
Name: matrix_deskew

Overview:
- Output-side counterpart of the input skew delay chain feeding the systolic matrix multiplier.
- The array emits result rows skewed in time: lane i of row r appears i cycles after lane 0.
- This block removes the skew per lane, reassembles complete rows, buffers them in a small FIFO, and delivers them downstream on a valid/ready handshake.
- It sits between the systolic array's south edge and the result writer.

Parameters:
LANES, 4, number of result lanes (array columns); legal range 2..16
WIDTH, 16, bits per result element
DEPTH, 4, row FIFO depth in entries; power of two, >=2

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  LANES  per-lane valid from array; bit i qualifies lane i
in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
clr_err  in  1  synchronous pulse; clears sticky error flags
out_valid  out  1  FIFO head row available
out_ready  in  1  downstream accepts row when out_valid && out_ready
out_data  out  LANES*WIDTH  aligned row, same lane packing as in_data
out_row  out  16  index of the row currently on out_data
misalign  out  1  sticky: partial aligned row detected
overflow  out  1  sticky: complete row dropped because FIFO full
level  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (reset==0, asynchronous): clear all delay stages (data and valid), FIFO pointers, level=0, out_valid=0, out_data=0, out_row=0, misalign=0, overflow=0, internal row counter=0. Release takes effect at the next clk edge.
- Deskew:
  - Lane i passes through LANES-1-i register stages (data and valid together); lane LANES-1 has zero stages.
  - Stages always shift, with no enable; the array cannot stall.
- Aligned row: the vector of deskewed valids and data in the current cycle.
  - all valids 1: complete row; push candidate.
  - all valids 0: idle; no action.
  - any other mix: misalign<=1; row discarded; no push.
- Push/pop:
  - A pop occurs when out_valid && out_ready.
  - A push occurs on a complete row when level<DEPTH, or when level==DEPTH and a pop happens in the same cycle.
  - A complete row with level==DEPTH and no pop: overflow<=1, row dropped, FIFO unchanged.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- Latency: a row whose lane-0 element is presented in cycle t appears on out_data with out_valid=1 in cycle t+LANES, if the FIFO was empty.
- out_data/out_valid: driven from FIFO head registers. out_data holds stable while out_valid && !out_ready.
- out_row:
  - Row index = count of rows pushed (including the one at the head) modulo 2^16, stored per entry.
  - The first row after reset has index 0.
  - Wraps 0xFFFF -> 0.
  - Dropped and misaligned rows do not consume an index.
- Sticky flags:
  - clr_err==1 clears both flags at the edge.
  - If a new error occurs in the same cycle as clr_err, the flag is set (set wins).
- Reset asserted mid-row: all partial deskew state and buffered rows are lost. No flag is set on release.
- out_valid = (level != 0). level updates on the same edge as the push/pop.

Test Plan (LANES=4, WIDTH=16, DEPTH=4):
1. Single row: lane i presents value 0x10+i with in_valid[i]=1 in cycle 2+i; out_ready=1 -> out_valid=1 in cycle 6 only, out_data={0x13,0x12,0x11,0x10}, out_row=0, flags 0.
2. Back-to-back stream: 8 consecutive skewed rows, row r lane i = r*4+i, out_ready=1 -> 8 consecutive out_valid cycles, data in order, out_row 0..7, level never exceeds 1.
3. Backpressure/overflow: out_ready=0, 5 complete rows -> level=4, overflow=1 after the 5th, out_data stays row 0. Then out_ready=1 -> rows 0..3 delivered, row 4 never appears.
4. Full with simultaneous pop: level=4, out_ready=1 in the same cycle a 5th row completes -> row accepted, level stays 4, overflow stays 0.
5. Misalignment: lane 2 valid withheld for one row -> misalign=1, no output for that row, the next good row gets the next out_row index. clr_err pulse -> misalign=0.
6. Async reset mid-stream: reset=0 for half a cycle while 3 rows are buffered -> out_valid=0, level=0, flags 0 immediately. A subsequent row emerges with out_row=0.
